// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the oversampling UART blocks.
//   PAR_NONE/PAR_ODD/PAR_EVEN : values of the PARITY parameter
//   rx_state_e                : receiver FSM state encoding
//   clog2()                   : ceiling log2, used to size counters
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Smallest r with 2**r >= value; 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick -- free-running oversample tick generator.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : restart the divider phase at 0 (used to align to a start edge)
//   tick : one-clock pulse every CLK_FQC/(BAUD*OVS) cycles
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FQC = 50_000_000,
  parameter int BAUD    = 9600,
  parameter int OVS     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_FQC / (BAUD * OVS);
  localparam int CW  = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The tick is the last count of each divider period; clr forces a fresh
  // period so the first tick after clr lands exactly DIV cycles later.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs -- parametrised oversampling UART receiver.
//   clk, rst         : system clock, synchronous active-high reset
//   rx               : asynchronous serial input, idles high
//   data             : received character (LSB first on the line)
//   valid / ready    : output handshake; data and error flags qualified by valid
//   frame_err        : some stop bit sampled low
//   parity_err       : parity mismatch (always 0 when PARITY is none)
//   overrun          : one-cycle pulse when a finished character is dropped
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_FQC   = 50_000_000,
  parameter int RX_BAUD   = 9600,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int SCW = (clog2(OVS) < 1) ? 1 : clog2(OVS);
  localparam int BCW = clog2(DATA_BITS + 1);

  localparam logic [SCW-1:0] SCNT_LAST = SCW'(OVS - 1);
  localparam logic [SCW-1:0] SMP_FIRST = SCW'(OVS / 2 - 1);
  localparam logic [SCW-1:0] SMP_MID   = SCW'(OVS / 2);
  localparam logic [SCW-1:0] SMP_DEC   = SCW'(OVS / 2 + 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
  localparam logic           ODD_INV   = (PARITY == PAR_ODD);

  logic rx_meta_q, rx_s_q, rx_q;

  rx_state_e state_q, state_d;
  logic [SCW-1:0]       scnt_q, scnt_d, scnt_nxt;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic tick, div_clr, bit_val, bit_dec, bit_wrap, deliver;

  uart_baud_tick #(
    .CLK_FQC(CLK_FQC),
    .BAUD   (RX_BAUD),
    .OVS    (OVS)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (div_clr),
    .tick(tick)
  );

  // Receiver FSM plus output register next-state logic. scnt_nxt is the
  // position within the bit that the current tick moves to; the three
  // samples are taken at positions OVS/2-1, OVS/2 and OVS/2+1, the last one
  // being the decision point. Bit boundaries are the ticks where scnt wraps.
  always_comb begin
    state_d      = state_q;
    scnt_d       = scnt_q;
    bcnt_d       = bcnt_q;
    samp_d       = samp_q;
    shreg_d      = shreg_q;
    ferr_d       = ferr_q;
    perr_d       = perr_q;
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    div_clr      = 1'b0;
    deliver      = 1'b0;

    scnt_nxt = (scnt_q == SCNT_LAST) ? '0 : scnt_q + SCW'(1);
    bit_val  = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s_q) | (samp_q[0] & rx_s_q);
    bit_dec  = tick && (scnt_nxt == SMP_DEC);
    bit_wrap = tick && (scnt_q == SCNT_LAST);

    if (state_q == RX_IDLE) begin
      // Only a genuine high-to-low transition starts a frame, so a line
      // stuck low cannot retrigger.
      if (rx_q && !rx_s_q) begin
        state_d = RX_START;
        scnt_d  = '0;
        bcnt_d  = '0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        div_clr = 1'b1;
      end
    end else if (tick) begin
      scnt_d = scnt_nxt;
      if (scnt_nxt == SMP_FIRST || scnt_nxt == SMP_MID) begin
        samp_d = {samp_q[0], rx_s_q};
      end
      case (state_q)
        RX_START: begin
          if (bit_dec && bit_val) begin
            state_d = RX_IDLE;
          end else if (bit_wrap) begin
            state_d = RX_DATA;
            bcnt_d  = '0;
          end
        end
        RX_DATA: begin
          if (bit_dec) begin
            shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
          end
          if (bit_wrap) begin
            if (bcnt_q == DATA_LAST) begin
              bcnt_d  = '0;
              state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              bcnt_d = bcnt_q + BCW'(1);
            end
          end
        end
        RX_PARITY: begin
          if (bit_dec) begin
            perr_d = bit_val ^ (^shreg_q) ^ ODD_INV;
          end
          if (bit_wrap) begin
            state_d = RX_STOP;
            bcnt_d  = '0;
          end
        end
        RX_STOP: begin
          if (bit_dec) begin
            if (!bit_val) begin
              ferr_d = 1'b1;
            end
            // Leave mid-way through the last stop bit to gain resync margin.
            if (bcnt_q == STOP_LAST) begin
              deliver = 1'b1;
              state_d = RX_IDLE;
            end
          end
          if (bit_wrap) begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end

    // A finished character is accepted when the output slot is empty or is
    // being emptied this cycle; otherwise the old one is kept.
    if (deliver) begin
      if (!valid_q || ready) begin
        data_d       = shreg_q;
        frame_err_d  = ferr_d;
        parity_err_d = perr_q;
        valid_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Synchroniser resets to the idle level so leaving reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_q         <= 1'b1;
      state_q      <= RX_IDLE;
      scnt_q       <= '0;
      bcnt_q       <= '0;
      samp_q       <= '0;
      shreg_q      <= '0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_q         <= rx_s_q;
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      bcnt_q       <= bcnt_d;
      samp_q       <= samp_d;
      shreg_q      <= shreg_d;
      ferr_q       <= ferr_d;
      perr_q       <= perr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs -- directed bench for uart_rx_ovs.
// Three receivers share clock and reset: A is 8N1, B is 8E1, C is 7O2.
// DIV = 10 clocks per tick, 160 clocks (3200 ns) per bit.
module tb_uart_rx_ovs;

  localparam int BIT_CYC = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       rxA = 1'b1, readyA = 1'b1;
  logic [7:0] dataA;
  logic       validA, feA, peA, ovA;

  logic       rxB = 1'b1, readyB = 1'b1;
  logic [7:0] dataB;
  logic       validB, feB, peB, ovB;

  logic       rxC = 1'b1, readyC = 1'b1;
  logic [6:0] dataC;
  logic       validC, feC, peC, ovC;

  int checkCount = 0;
  int errorCount = 0;

  // {frame_err, parity_err, 1'b0, data} captured on each rising valid
  logic [10:0] recA[$];
  logic [10:0] recB[$];
  logic [10:0] recC[$];
  logic prevValidA = 1'b0, prevValidB = 1'b0, prevValidC = 1'b0;
  int ovCountA = 0;

  always #10 clk = ~clk;

  uart_rx_ovs #(.CLK_FQC(50_000_000), .RX_BAUD(312_500), .OVS(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
    .clk(clk), .rst(rst), .rx(rxA), .data(dataA), .valid(validA),
    .ready(readyA), .frame_err(feA), .parity_err(peA), .overrun(ovA));

  uart_rx_ovs #(.CLK_FQC(50_000_000), .RX_BAUD(312_500), .OVS(16),
                .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dutB (
    .clk(clk), .rst(rst), .rx(rxB), .data(dataB), .valid(validB),
    .ready(readyB), .frame_err(feB), .parity_err(peB), .overrun(ovB));

  uart_rx_ovs #(.CLK_FQC(50_000_000), .RX_BAUD(312_500), .OVS(16),
                .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dutC (
    .clk(clk), .rst(rst), .rx(rxC), .data(dataC), .valid(validC),
    .ready(readyC), .frame_err(feC), .parity_err(peC), .overrun(ovC));

  // Record every delivered character and count overrun cycles on A.
  always @(negedge clk) begin
    if (validA && !prevValidA) recA.push_back({feA, peA, 1'b0, dataA});
    if (validB && !prevValidB) recB.push_back({feB, peB, 1'b0, dataB});
    if (validC && !prevValidC) recC.push_back({feC, peC, 2'b00, dataC});
    if (ovA) ovCountA = ovCountA + 1;
    prevValidA <= validA;
    prevValidB <= validB;
    prevValidC <= validC;
  end

  task automatic driveLine(input int line, input logic v);
    case (line)
      0: rxA = v;
      1: rxB = v;
      default: rxC = v;
    endcase
  endtask

  // Drives nBits frame bits LSB first, BIT_CYC clocks each. glitchBit >= 0
  // inverts that frame bit for 6 clocks around its centre sample only.
  task automatic applyStimulus(input int line, input logic [15:0] bits,
                               input int nBits, input int glitchBit);
    logic v;
    @(posedge clk);
    #1;
    for (int b = 0; b < nBits; b++) begin
      for (int c = 0; c < BIT_CYC; c++) begin
        v = bits[b];
        if (b == glitchBit && c >= 79 && c < 85) v = ~v;
        driveLine(line, v);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checkCount++;
    if ({validA, validB, validC} !== 3'b000) begin
      errorCount++;
      $display("[TB] FAIL reset_valid: got %b expected 000", {validA, validB, validC});
    end
    checkCount++;
    if ({dataA, feA, peA, ovA} !== 11'd0) begin
      errorCount++;
      $display("[TB] FAIL reset_outA: got %h expected 000", {dataA, feA, peA, ovA});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkCount++;
    if ({validA, validB, validC, ovA} !== 4'b0000) begin
      errorCount++;
      $display("[TB] FAIL after_reset_idle: got %b expected 0000", {validA, validB, validC, ovA});
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = recA.size();
    applyStimulus(0, {6'b0, 1'b1, 8'hAF, 1'b0}, 10, -1);
    applyStimulus(0, {6'b0, 1'b1, 8'h56, 1'b0}, 10, -1);
    repeat (200) @(posedge clk);
    checkCount++;
    if (recA.size() !== base + 2) begin
      errorCount++;
      $display("[TB] FAIL b2b_count: got %0d expected %0d", recA.size() - base, 2);
    end
    if (recA.size() >= base + 2) begin
      checkCount++;
      if (recA[base] !== 11'h0AF) begin
        errorCount++;
        $display("[TB] FAIL b2b_first: got %h expected 0af", recA[base]);
      end
      checkCount++;
      if (recA[base+1] !== 11'h056) begin
        errorCount++;
        $display("[TB] FAIL b2b_second: got %h expected 056", recA[base+1]);
      end
    end
  endtask

  task automatic test_parity;
    int base;
    base = recB.size();
    applyStimulus(1, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, -1);
    applyStimulus(1, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, -1);
    repeat (200) @(posedge clk);
    checkCount++;
    if (recB.size() !== base + 2) begin
      errorCount++;
      $display("[TB] FAIL parity_count: got %0d expected %0d", recB.size() - base, 2);
    end
    if (recB.size() >= base + 2) begin
      checkCount++;
      if (recB[base] !== 11'h0A5) begin
        errorCount++;
        $display("[TB] FAIL parity_good: got %h expected 0a5", recB[base]);
      end
      checkCount++;
      if (recB[base+1] !== 11'h2A5) begin
        errorCount++;
        $display("[TB] FAIL parity_bad: got %h expected 2a5", recB[base+1]);
      end
    end
  endtask

  task automatic test_frame_error;
    int base;
    base = recC.size();
    // 0x3C has four ones, so the odd parity bit is 1; second stop bit low.
    applyStimulus(2, {5'b0, 1'b0, 1'b1, 1'b1, 7'h3C, 1'b0}, 11, -1);
    repeat (10 * BIT_CYC) @(posedge clk);
    checkCount++;
    if (recC.size() !== base + 1) begin
      errorCount++;
      $display("[TB] FAIL ferr_count: got %0d expected %0d", recC.size() - base, 1);
    end
    if (recC.size() >= base + 1) begin
      checkCount++;
      if (recC[base] !== 11'h43C) begin
        errorCount++;
        $display("[TB] FAIL ferr_char: got %h expected 43c", recC[base]);
      end
    end
    #1 rxC = 1'b1;
    repeat (2 * BIT_CYC) @(posedge clk);
    checkCount++;
    if (recC.size() !== base + 1) begin
      errorCount++;
      $display("[TB] FAIL low_line_retrigger: got %0d expected %0d", recC.size() - base, 1);
    end
    // 0x55 (7 bits) has four ones: odd parity bit 1, both stops good.
    applyStimulus(2, {5'b0, 1'b1, 1'b1, 1'b1, 7'h55, 1'b0}, 11, -1);
    repeat (200) @(posedge clk);
    checkCount++;
    if (recC.size() !== base + 2) begin
      errorCount++;
      $display("[TB] FAIL recover_count: got %0d expected %0d", recC.size() - base, 2);
    end
    if (recC.size() >= base + 2) begin
      checkCount++;
      if (recC[base+1] !== 11'h055) begin
        errorCount++;
        $display("[TB] FAIL recover_char: got %h expected 055", recC[base+1]);
      end
    end
  endtask

  task automatic test_glitch;
    int base;
    base = recA.size();
    @(posedge clk);
    #1 rxA = 1'b0;
    repeat (15) @(posedge clk);
    #1 rxA = 1'b1;
    repeat (400) @(posedge clk);
    checkCount++;
    if (recA.size() !== base) begin
      errorCount++;
      $display("[TB] FAIL idle_glitch: got %0d expected %0d", recA.size() - base, 0);
    end
    // Frame bit 4 is data bit 3 (a 0 in 0x96), flipped at its centre sample.
    applyStimulus(0, {6'b0, 1'b1, 8'h96, 1'b0}, 10, 4);
    repeat (200) @(posedge clk);
    checkCount++;
    if (recA.size() !== base + 1) begin
      errorCount++;
      $display("[TB] FAIL data_glitch_count: got %0d expected %0d", recA.size() - base, 1);
    end
    if (recA.size() >= base + 1) begin
      checkCount++;
      if (recA[base] !== 11'h096) begin
        errorCount++;
        $display("[TB] FAIL data_glitch_char: got %h expected 096", recA[base]);
      end
    end
  endtask

  task automatic test_overrun;
    int base, ovBase;
    #1 readyA = 1'b0;
    base   = recA.size();
    ovBase = ovCountA;
    applyStimulus(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, -1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    checkCount++;
    if ({validA, dataA} !== 9'h111) begin
      errorCount++;
      $display("[TB] FAIL hold_first: got %h expected 111", {validA, dataA});
    end
    applyStimulus(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, -1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    checkCount++;
    if ({validA, dataA} !== 9'h111) begin
      errorCount++;
      $display("[TB] FAIL hold_after_drop: got %h expected 111", {validA, dataA});
    end
    checkCount++;
    if (ovCountA - ovBase !== 1) begin
      errorCount++;
      $display("[TB] FAIL overrun_pulse: got %0d expected %0d", ovCountA - ovBase, 1);
    end
    checkCount++;
    if (recA.size() !== base + 1) begin
      errorCount++;
      $display("[TB] FAIL overrun_rises: got %0d expected %0d", recA.size() - base, 1);
    end
    // Stop decision lands on edge 1533 after the frame's first edge; ready
    // is high only for the cycle ending at that edge.
    @(posedge clk);
    fork
      applyStimulus(0, {6'b0, 1'b1, 8'h33, 1'b0}, 10, -1);
      begin
        repeat (1533) @(posedge clk);
        #1 readyA = 1'b1;
        @(posedge clk);
        #1 readyA = 1'b0;
      end
    join
    repeat (100) @(posedge clk);
    @(negedge clk);
    checkCount++;
    if ({validA, feA, peA, dataA} !== 11'h433) begin
      errorCount++;
      $display("[TB] FAIL same_cycle_reload: got %h expected 433", {validA, feA, peA, dataA});
    end
    checkCount++;
    if (ovCountA - ovBase !== 1) begin
      errorCount++;
      $display("[TB] FAIL reload_no_overrun: got %0d expected %0d", ovCountA - ovBase, 1);
    end
  endtask

  task automatic test_reset_mid_frame;
    int base;
    base = recA.size();
    @(posedge clk);
    fork
      applyStimulus(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, -1);
      begin
        repeat (881) @(posedge clk);
        #1 rst = 1'b1;
      end
    join
    repeat (100) @(posedge clk);
    @(negedge clk);
    checkCount++;
    if ({validA, feA, peA, ovA, dataA} !== 12'h000) begin
      errorCount++;
      $display("[TB] FAIL midframe_reset_out: got %h expected 000", {validA, feA, peA, ovA, dataA});
    end
    #1 rst = 1'b0;
    readyA = 1'b1;
    repeat (50) @(posedge clk);
    checkCount++;
    if (recA.size() !== base) begin
      errorCount++;
      $display("[TB] FAIL midframe_no_valid: got %0d expected %0d", recA.size() - base, 0);
    end
    applyStimulus(0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10, -1);
    repeat (200) @(posedge clk);
    checkCount++;
    if (recA.size() !== base + 1) begin
      errorCount++;
      $display("[TB] FAIL post_reset_count: got %0d expected %0d", recA.size() - base, 1);
    end
    if (recA.size() >= base + 1) begin
      checkCount++;
      if (recA[base] !== 11'h0C3) begin
        errorCount++;
        $display("[TB] FAIL post_reset_char: got %h expected 0c3", recA[base]);
      end
    end
  endtask

  initial begin
    $display("[TB] uart_rx_ovs bench start");
    repeat (5) @(posedge clk);
    test_reset();
    test_back_to_back();
    test_parity();
    test_frame_error();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
